// File: rtl/dds_cmd_parser.sv
// Decodes 7-byte parameter-write frames (55 AA ch cmd vh vl xor) for one DDS channel.
// Define DDS_CMD_TIMEOUT_EN to abandon frames that stall longer than P_TIMEOUT cycles.
module dds_cmd_parser #(
  parameter logic [7:0] P_CNT     = 8'd0,
  parameter int         P_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_vld,
  input  logic        i_rx_last,
  output logic        o_dds_run,
  output logic        o_dds_run_vld,
  output logic [2:0]  o_dds_type,
  output logic        o_dds_type_vld,
  output logic [15:0] o_dds_frq,
  output logic        o_dds_frq_vld,
  output logic [11:0] o_dds_amp,
  output logic        o_dds_amp_vld,
  output logic [12:0] o_dds_p2p,
  output logic        o_dds_p2p_vld,
  output logic [12:0] o_dds_offset,
  output logic        o_dds_offset_vld,
  output logic [11:0] o_dds_phase,
  output logic        o_dds_phase_vld,
  output logic [9:0]  o_dds_duty,
  output logic        o_dds_duty_vld,
  output logic [7:0]  o_err_cnt
);
  typedef enum logic [2:0] {IDLE, SYNC, CH, CMD, VH, VL, CHK} state_e;

  state_e      state_q;
  logic [7:0]  ch_q, cmd_q, vh_q, vl_q;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        run_q, run_vld_q, type_vld_q, frq_vld_q, amp_vld_q;
  logic        p2p_vld_q, offset_vld_q, phase_vld_q, duty_vld_q;
  logic [2:0]  type_q;
  logic [15:0] frq_q;
  logic [11:0] amp_q, phase_q;
  logic [12:0] p2p_q, offset_q;
  logic [9:0]  duty_q;

  logic [15:0] val;
  logic        in_range, csum_ok, ch_hit, chk_byte, accept, reject, abort, timeout, err_ev;

  always_comb begin
    val      = {vh_q, vl_q};
    in_range = 1'b0;
    case (cmd_q)
      8'h01:   in_range = (val <= 16'd1);
      8'h02:   in_range = (val <= 16'd7);
      8'h03:   in_range = (val <= 16'd50000);
      8'h04:   in_range = (val <= 16'd3000);
      8'h05:   in_range = (val <= 16'd6000);
      8'h06:   in_range = (val <= 16'd6000);
      8'h07:   in_range = (val <= 16'd3600);
      8'h08:   in_range = (val <= 16'd1000);
      default: in_range = 1'b0;
    endcase
    csum_ok  = ((ch_q ^ cmd_q ^ vh_q ^ vl_q) == i_rx_data);
    ch_hit   = (ch_q == P_CNT) || (ch_q == 8'hFF);
    chk_byte = i_rx_vld && (state_q == CHK);
    accept   = chk_byte && csum_ok && ch_hit && in_range;
    // Foreign-channel frames with a good checksum are dropped without counting an error.
    reject   = chk_byte && (!csum_ok || (ch_hit && !in_range));
    // A 0x55 in IDLE opens a frame, so a last flag on it is also a truncated frame.
    abort    = i_rx_vld && i_rx_last &&
               ((state_q == IDLE) ? (i_rx_data == 8'h55) : (state_q != CHK));
    err_ev   = abort || reject || timeout;
    err_cnt_d = (err_ev && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

`ifdef DDS_CMD_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign timeout = (state_q != IDLE) && !i_rx_vld && (tmo_cnt_q == TW'(P_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q == IDLE || i_rx_vld || timeout) tmo_cnt_q <= '0;
    else                                                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      cmd_q        <= '0;
      vh_q         <= '0;
      vl_q         <= '0;
      err_cnt_q    <= '0;
      run_q        <= '0;
      type_q       <= '0;
      frq_q        <= '0;
      amp_q        <= '0;
      p2p_q        <= '0;
      offset_q     <= '0;
      phase_q      <= '0;
      duty_q       <= 10'd500;
      run_vld_q    <= 1'b0;
      type_vld_q   <= 1'b0;
      frq_vld_q    <= 1'b0;
      amp_vld_q    <= 1'b0;
      p2p_vld_q    <= 1'b0;
      offset_vld_q <= 1'b0;
      phase_vld_q  <= 1'b0;
      duty_vld_q   <= 1'b0;
    end else begin
      run_vld_q    <= 1'b0;
      type_vld_q   <= 1'b0;
      frq_vld_q    <= 1'b0;
      amp_vld_q    <= 1'b0;
      p2p_vld_q    <= 1'b0;
      offset_vld_q <= 1'b0;
      phase_vld_q  <= 1'b0;
      duty_vld_q   <= 1'b0;
      err_cnt_q    <= err_cnt_d;
      if (accept) begin
        case (cmd_q)
          8'h01:   begin run_q    <= val[0];     run_vld_q    <= 1'b1; end
          8'h02:   begin type_q   <= val[2:0];   type_vld_q   <= 1'b1; end
          8'h03:   begin frq_q    <= val;        frq_vld_q    <= 1'b1; end
          8'h04:   begin amp_q    <= val[11:0];  amp_vld_q    <= 1'b1; end
          8'h05:   begin p2p_q    <= val[12:0];  p2p_vld_q    <= 1'b1; end
          8'h06:   begin offset_q <= val[12:0];  offset_vld_q <= 1'b1; end
          8'h07:   begin phase_q  <= val[11:0];  phase_vld_q  <= 1'b1; end
          8'h08:   begin duty_q   <= val[9:0];   duty_vld_q   <= 1'b1; end
          default: ;
        endcase
      end
      if (i_rx_vld) begin
        if (abort) state_q <= IDLE;
        else begin
          case (state_q)
            IDLE:    if (i_rx_data == 8'h55) state_q <= SYNC;
            SYNC:    if (i_rx_data == 8'hAA) state_q <= CH;
                     else if (i_rx_data != 8'h55) state_q <= IDLE;
            CH:      begin ch_q  <= i_rx_data; state_q <= CMD; end
            CMD:     begin cmd_q <= i_rx_data; state_q <= VH;  end
            VH:      begin vh_q  <= i_rx_data; state_q <= VL;  end
            VL:      begin vl_q  <= i_rx_data; state_q <= CHK; end
            default: state_q <= IDLE;
          endcase
        end
      end else if (timeout) begin
        state_q <= IDLE;
      end
    end
  end

  assign o_dds_run        = run_q;
  assign o_dds_run_vld    = run_vld_q;
  assign o_dds_type       = type_q;
  assign o_dds_type_vld   = type_vld_q;
  assign o_dds_frq        = frq_q;
  assign o_dds_frq_vld    = frq_vld_q;
  assign o_dds_amp        = amp_q;
  assign o_dds_amp_vld    = amp_vld_q;
  assign o_dds_p2p        = p2p_q;
  assign o_dds_p2p_vld    = p2p_vld_q;
  assign o_dds_offset     = offset_q;
  assign o_dds_offset_vld = offset_vld_q;
  assign o_dds_phase      = phase_q;
  assign o_dds_phase_vld  = phase_vld_q;
  assign o_dds_duty       = duty_q;
  assign o_dds_duty_vld   = duty_vld_q;
  assign o_err_cnt        = err_cnt_q;
endmodule

// File: tb/tb_dds_cmd_parser.sv
// Bench for dds_cmd_parser: two instances (channel 0 and 1) share one byte stream.
module tb_dds_cmd_parser;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_vld = 1'b0;
  logic       rx_last = 1'b0;

  logic [15:0] val [2][8];
  logic [7:0]  vld [2];
  logic [7:0]  err [2];
  int          pulses [2] = '{0, 0};
  int          n_pass = 0;
  int          n_tot = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        run, run_v, typ_v, frq_v, amp_v, p2p_v, off_v, ph_v, duty_v;
    logic [2:0]  typ;
    logic [15:0] frq;
    logic [11:0] amp, ph;
    logic [12:0] p2p, off;
    logic [9:0]  duty;
    logic [7:0]  ec;
    dds_cmd_parser #(.P_CNT(8'(g)), .P_TIMEOUT(1024)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_vld(rx_vld), .i_rx_last(rx_last),
      .o_dds_run(run), .o_dds_run_vld(run_v), .o_dds_type(typ), .o_dds_type_vld(typ_v),
      .o_dds_frq(frq), .o_dds_frq_vld(frq_v), .o_dds_amp(amp), .o_dds_amp_vld(amp_v),
      .o_dds_p2p(p2p), .o_dds_p2p_vld(p2p_v), .o_dds_offset(off), .o_dds_offset_vld(off_v),
      .o_dds_phase(ph), .o_dds_phase_vld(ph_v), .o_dds_duty(duty), .o_dds_duty_vld(duty_v),
      .o_err_cnt(ec));
    assign val[g][0] = 16'(run);
    assign val[g][1] = 16'(typ);
    assign val[g][2] = frq;
    assign val[g][3] = 16'(amp);
    assign val[g][4] = 16'(p2p);
    assign val[g][5] = 16'(off);
    assign val[g][6] = 16'(ph);
    assign val[g][7] = 16'(duty);
    assign vld[g]    = {duty_v, ph_v, off_v, p2p_v, amp_v, frq_v, typ_v, run_v};
    assign err[g]    = ec;
  end

  // Every cycle any _vld is high adds to the count; a stretched or doubled pulse shows up here.
  always @(negedge clk)
    for (int i = 0; i < 2; i++) pulses[i] = pulses[i] + $countones(vld[i]);

  // Reference model: field index = cmd-1, legal upper bound per field.
  int         lim [8] = '{1, 7, 50000, 3000, 6000, 6000, 3600, 1000};
  int         mval [2][8];
  int         merr [2];
  int         mpulse [2] = '{0, 0};
  logic [7:0] emask [2];

  function automatic void bump(input int i);
    if (merr[i] < 255) merr[i]++;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int f = 0; f < 8; f++) mval[i][f] = 0;
      mval[i][7] = 500;
      merr[i]    = 0;
    end
  endfunction

  function automatic void model_frame(input logic [7:0] ch, cmd, vh, vl, ck, input bit ab);
    int v;
    v = int'({vh, vl});
    for (int i = 0; i < 2; i++) begin
      emask[i] = 8'h00;
      if (ab || ((ch ^ cmd ^ vh ^ vl) != ck)) bump(i);
      else if (ch == 8'(i) || ch == 8'hFF) begin
        if (cmd < 8'd1 || cmd > 8'd8 || v > lim[cmd-1]) bump(i);
        else begin
          mval[i][cmd-1] = v;
          mpulse[i]++;
          emask[i][cmd-1] = 1'b1;
        end
      end
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    @(negedge clk);
    rx_data = b; rx_vld = 1'b1; rx_last = l;
    @(posedge clk); #1;
    rx_vld = 1'b0; rx_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic check_state(input string tag);
    idle(2);
    for (int i = 0; i < 2; i++) begin
      for (int f = 0; f < 8; f++)
        check($sformatf("%s u%0d field%0d", tag, i, f), 32'(val[i][f]), mval[i][f]);
      check($sformatf("%s u%0d err_cnt", tag, i), 32'(err[i]), merr[i]);
      check($sformatf("%s u%0d pulse_count", tag, i), pulses[i], mpulse[i]);
    end
  endtask

  // ab_at: byte index carrying an early last flag (0 = complete frame).
  task automatic frame(input logic [7:0] ch, cmd, vh, vl, ck, input int ab_at, input bit last_ok);
    logic [7:0] fb [7];
    int n;
    fb = '{8'h55, 8'hAA, ch, cmd, vh, vl, ck};
    n  = (ab_at != 0) ? ab_at + 1 : 7;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(fb[k], (k == n - 1) && (ab_at != 0 || last_ok));
    end
    model_frame(ch, cmd, vh, vl, ck, ab_at != 0);
    for (int i = 0; i < 2; i++) check($sformatf("frame u%0d vld", i), 32'(vld[i]), 32'(emask[i]));
  endtask

  typedef struct {
    logic [63:0] b;
    int n; int la;
    logic [7:0] m0; logic [7:0] m1;
    int e0; int e1; int v0; int v1;
  } vec_t;

  initial begin
    vec_t tv [10];
    logic [7:0]  b, ch, cmd, ck;
    logic [15:0] v;
    int ab;
    tv[0] = '{64'h55AA0003C3509000, 7, 6, 8'h04, 8'h00, 0, 0, 50000, 0};
    tv[1] = '{64'h55AA0003C3519100, 7, 6, 8'h00, 8'h00, 1, 0, 0, 0};
    tv[2] = '{64'h55AA00040BB80000, 7, 6, 8'h00, 8'h00, 2, 1, 0, 0};
    tv[3] = '{64'h5555AAFF08012CDA, 8, 7, 8'h80, 8'h80, 2, 1, 300, 300};
    tv[4] = '{64'h55AA010200050600, 7, 6, 8'h00, 8'h02, 2, 1, 0, 5};
    tv[5] = '{64'h55AA00040B000000, 5, 4, 8'h00, 8'h00, 3, 2, 0, 0};
    tv[6] = '{64'h55AA00040BB8B700, 7, 6, 8'h08, 8'h00, 3, 2, 3000, 0};
    tv[7] = '{64'h55AA000707080800, 7, 6, 8'h40, 8'h00, 3, 2, 1800, 0};
    tv[8] = '{64'h55AAFF090001F700, 7, 6, 8'h00, 8'h00, 4, 3, 0, 0};
    tv[9] = '{64'h55AAFF010001FF00, 7, 6, 8'h01, 8'h01, 4, 3, 1, 1};

    idle(3);
    do_reset();
    check_state("reset");

    // Directed frames, sent back to back with no idle gap.
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < tv[t].n; k++) send(tv[t].b[63-8*k -: 8], k == tv[t].la);
      check($sformatf("vec%0d u0 vld", t), 32'(vld[0]), 32'(tv[t].m0));
      check($sformatf("vec%0d u1 vld", t), 32'(vld[1]), 32'(tv[t].m1));
      check($sformatf("vec%0d u0 err", t), 32'(err[0]), tv[t].e0);
      check($sformatf("vec%0d u1 err", t), 32'(err[1]), tv[t].e1);
      for (int f = 0; f < 8; f++) begin
        if (tv[t].m0[f]) begin
          check($sformatf("vec%0d u0 value", t), 32'(val[0][f]), tv[t].v0);
          mval[0][f] = tv[t].v0;
        end
        if (tv[t].m1[f]) begin
          check($sformatf("vec%0d u1 value", t), 32'(val[1][f]), tv[t].v1);
          mval[1][f] = tv[t].v1;
        end
      end
      mpulse[0] += $countones(tv[t].m0);
      mpulse[1] += $countones(tv[t].m1);
      merr[0] = tv[t].e0;
      merr[1] = tv[t].e1;
    end
    check_state("table");

    // Reset in the middle of a duty frame: tail bytes must not produce anything.
    send(8'h55, 1'b0); send(8'hAA, 1'b0); send(8'h00, 1'b0); send(8'h08, 1'b0);
    do_reset();
    send(8'h01, 1'b0); send(8'h2C, 1'b0); send(8'hDA, 1'b1);
    check_state("midreset");

    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h00;
        send(b, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) send(8'h55, 1'b0);
      case ($urandom_range(0, 3))
        0:       ch = 8'h00;
        1:       ch = 8'h01;
        2:       ch = 8'hFF;
        default: ch = 8'($urandom);
      endcase
      cmd = 8'($urandom_range(0, 9));
      if (cmd >= 8'd1 && cmd <= 8'd8 && $urandom_range(0, 3) != 0)
        v = 16'($urandom_range(0, lim[cmd-1]));
      else
        v = 16'($urandom);
      ck = ch ^ cmd ^ v[15:8] ^ v[7:0];
      if ($urandom_range(0, 7) == 0) ck = ck ^ (8'h01 << $urandom_range(0, 7));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : 0;
      frame(ch, cmd, v[15:8], v[7:0], ck, ab, 1'($urandom_range(0, 1)));
    end
    check_state("random");

`ifdef DDS_CMD_TIMEOUT_EN
    send(8'h55, 1'b0); send(8'hAA, 1'b0); send(8'h00, 1'b0); send(8'h04, 1'b0);
    idle(1100);
    bump(0); bump(1);
    check_state("timeout");
    frame(8'h00, 8'h08, 8'h01, 8'h2C, 8'hDA, 0, 1'b1);
    check_state("after_timeout");
`endif

    for (int k = 0; k < 260; k++) begin
      send(8'h55, 1'b0); send(8'hAA, 1'b1);
      bump(0); bump(1);
    end
    check_state("saturate");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
